// File: rtl/gf2mul_pkg.sv
// rtl/gf2mul_pkg.sv - shared constants and types for the sequenced GF(2) multiplier
package gf2mul_pkg;

  localparam int DIGIT      = 8;
  localparam int NUM_DIGITS = 4;
  localparam int NUM_PAIRS  = NUM_DIGITS * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  typedef logic [$clog2(NUM_PAIRS)-1:0] pair_idx_t;
  typedef logic [DIGIT-1:0]             digit_t;

endpackage

// File: rtl/clmul_serial_digit.sv
// rtl/clmul_serial_digit.sv - bit-serial DIGITxDIGIT carry-less digit multiplier
module clmul_serial_digit #(
  parameter int DIGIT = gf2mul_pkg::DIGIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT-1:0]   a_d,
  input  logic [DIGIT-1:0]   b_d,
  output logic [2*DIGIT-2:0] pp,
  output logic               done
);

  localparam int BW = $clog2(DIGIT);

  logic [BW-1:0] bit_cnt;
  logic          running;

  // done marks the cycle in which the last bit of a_d is folded in
  assign done = running && (bit_cnt == BW'(DIGIT - 1));

  // start clears pp and arms DIGIT steps; each step XORs in b_d << k when a_d[k] is set
  always_ff @(posedge clk) begin
    if (rst) begin
      pp      <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
    end else if (start) begin
      pp      <= '0;
      bit_cnt <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (a_d[bit_cnt]) begin
        pp <= pp ^ ({{(DIGIT-1){1'b0}}, b_d} << bit_cnt);
      end
      if (done) begin
        running <= 1'b0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf2_mul_scheduler.sv
// rtl/gf2_mul_scheduler.sv - sequenced WIDTHxWIDTH carry-less multiplier; SKIP_ZERO_EN skips zero digit pairs
module gf2_mul_scheduler #(
  parameter int WIDTH = gf2mul_pkg::DIGIT * gf2mul_pkg::NUM_DIGITS,
  parameter int DIGIT = gf2mul_pkg::DIGIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  import gf2mul_pkg::*;

  localparam int ND = WIDTH / DIGIT;
  localparam int NP = ND * ND;
  localparam int PW = $clog2(NP);
  localparam int IW = $clog2(ND);

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc, acc_next, pp_shifted;
  logic [PW-1:0]        pair;
  logic [IW-1:0]        i_idx, j_idx;
  logic [DIGIT-1:0]     a_d, b_d;
  logic [2*DIGIT-2:0]   pp;
  logic                 mul_start, mul_done, accept, last_pair;
  logic                 acc_step, pair_adv, finish, skip;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_ready && in_valid;
  assign last_pair = (pair == PW'(NP - 1));
  assign i_idx     = IW'(pair / PW'(ND));
  assign j_idx     = IW'(pair % PW'(ND));
  assign a_d       = a_q[i_idx*DIGIT +: DIGIT];
  assign b_d       = b_q[j_idx*DIGIT +: DIGIT];

`ifdef SKIP_ZERO_EN
  logic first_mul;

  // first_mul is high only in the first MUL cycle of each pair
  always_ff @(posedge clk) begin
    if (rst) first_mul <= 1'b0;
    else     first_mul <= mul_start;
  end

  assign skip = (state == MUL) && first_mul && ((a_d == '0) || (b_d == '0));
`else
  assign skip = 1'b0;
`endif

  clmul_serial_digit #(.DIGIT(DIGIT)) u_digit (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a_d   (a_d),
    .b_d   (b_d),
    .pp    (pp),
    .done  (mul_done)
  );

  // place the partial product at its digit offset; the upper bit of c can never be reached
  always_comb begin
    pp_shifted = {{(2*WIDTH-2*DIGIT+1){1'b0}}, pp} << (DIGIT * (int'(i_idx) + int'(j_idx)));
    acc_next   = acc ^ (acc_step ? pp_shifted : '0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    acc_step   = 1'b0;
    pair_adv   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = MUL;
          mul_start  = 1'b1;
        end
      end
      MUL: begin
        if (skip) begin
          if (last_pair) begin
            state_next = DONE;
            finish     = 1'b1;
          end else begin
            pair_adv  = 1'b1;
            mul_start = 1'b1;
          end
        end else if (mul_done) begin
          state_next = ACC;
        end
      end
      ACC: begin
        acc_step = 1'b1;
        if (last_pair) begin
          state_next = DONE;
          finish     = 1'b1;
        end else begin
          state_next = MUL;
          pair_adv   = 1'b1;
          mul_start  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand latch, accumulator, pair counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      pair      <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        acc  <= '0;
        pair <= '0;
      end
      if (acc_step) acc  <= acc_next;
      if (pair_adv) pair <= pair + 1'b1;
      if (finish) begin
        c         <= acc_next;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
